sprite_rom_arbiter: RTL

Shares one single-port sprite ROM read port between the hero renderer and the monster renderers. It sits between the per-sprite address generators in the VGA selection path and a sprite block-ROM clocked by `clk_vga`. Each cycle it issues at most one ROM read, chosen by round-robin. The returned pixel byte is tagged back to the requester that asked for it, so every sprite shares one ROM instead of owning a duplicated core.

---
 rtl/sprite_pkg.sv | 12 +
 rtl/rr_pick.sv | 35 +++
 rtl/sprite_rom_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite constants and pixel type for the ROM-sharing arbiters
package sprite_pkg;

   localparam int N_MONSTERS    = 12;
   localparam int SPRITE_ADDR_W = 9;
   localparam int PIXEL_W       = 8;
   localparam int HERO_IDX      = 0;

   // RGB 3-3-2 pixel byte as stored in the sprite ROM
   typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder (first set bit at or after start, wrapping)
module rr_pick #(
   parameter int N     = 13,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Two passes with constant indices: first the upper segment [start, N-1], then the wrapped
   // segment [0, start-1]; the first set bit found wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (IDX_W'(i) >= start)) begin
            any       = 1'b1;
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (IDX_W'(i) < start)) begin
            any       = 1'b1;
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of one sprite ROM read port (option: SPRITE_ARB_HERO_PRIO_EN)
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int REQUESTERS = N_MONSTERS + 1,
   parameter int ADDR_W     = SPRITE_ADDR_W,
   parameter int DATA_W     = PIXEL_W,
   parameter int ROM_LAT    = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [REQUESTERS-1:0]        req,
   input  logic [REQUESTERS*ADDR_W-1:0] req_addr,
   output logic [REQUESTERS-1:0]        gnt,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [DATA_W-1:0]            rom_data,
   output logic [REQUESTERS-1:0]        rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         busy
);

   localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   logic [REQUESTERS-1:0]               gnt_q, gnt_d;
   logic [ADDR_W-1:0]                   rom_addr_q, rom_addr_d;
   logic [IDX_W-1:0]                    ptr_q, ptr_d;
   logic [ROM_LAT-1:0][REQUESTERS-1:0]  tag_q, tag_d;

   logic [REQUESTERS-1:0]               eligible;
   logic [REQUESTERS-1:0]               pick_req;
   logic [REQUESTERS-1:0]               pick_oh;
   logic [IDX_W-1:0]                    pick_idx;
   logic                                pick_any;
   logic                                hero_win;

   // The current grantee is masked so a requester still holding req is not granted twice.
   assign eligible = req & ~gnt_q;

`ifdef SPRITE_ARB_HERO_PRIO_EN
   // Hero bypasses the rotation; monsters rotate among themselves.
   assign hero_win = eligible[HERO_IDX];
   assign pick_req = eligible & ~(REQUESTERS'(1) << HERO_IDX);
`else
   assign hero_win = 1'b0;
   assign pick_req = eligible;
`endif

   rr_pick #(
      .N     (REQUESTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (pick_req),
      .start  (ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Next grant, ROM address and rotation pointer; address and pointer hold when idle.
   always_comb begin
      gnt_d      = '0;
      rom_addr_d = rom_addr_q;
      ptr_d      = ptr_q;
      if (hero_win) begin
         gnt_d[HERO_IDX] = 1'b1;
         rom_addr_d      = req_addr[HERO_IDX*ADDR_W +: ADDR_W];
      end else if (pick_any) begin
         gnt_d      = pick_oh;
         rom_addr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
         ptr_d      = (pick_idx == IDX_W'(REQUESTERS-1)) ? '0 : pick_idx + IDX_W'(1);
      end
   end

   // Tag shift register: the grant enters stage 0 and emerges as rd_valid ROM_LAT cycles later.
   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = gnt_q;
      for (int s = 1; s < ROM_LAT; s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   // State registers; reset drops in-flight tags so returning ROM data is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q      <= '0;
         rom_addr_q <= '0;
         ptr_q      <= '0;
         tag_q      <= '0;
      end else begin
         gnt_q      <= gnt_d;
         rom_addr_q <= rom_addr_d;
         ptr_q      <= ptr_d;
         tag_q      <= tag_d;
      end
   end

   assign gnt      = gnt_q;
   assign rom_addr = rom_addr_q;
   assign rd_valid = tag_q[ROM_LAT-1];
   assign rd_data  = rom_data;
   assign busy     = (|req) | (|gnt_q) | (|tag_q);

endmodule
